i2c_bus_filter_mc: RTL
======================

Name: i2c_bus_filter_mc

Overview:
Multi-channel I2C input conditioner and bus monitor for CH independent I2C buses. Per channel it:
- synchronises the SCL/SDA pad inputs and removes glitches with a DEPTH-tap majority filter clocked by a shared prescaler;
- detects START, repeated START, STOP and SCL edges, and tracks bus busy;
- flags SCL-low (clock-stretch) timeouts and measures SCL high/low periods.

It sits between the pad tristate logic at top level and the I2C master/slave controllers.

Parameters:
CH, 2, number of independent I2C channels (>=1)
DEPTH, 3, majority-filter taps per line; odd, 3..15
PRE_W, 14, prescaler reload width
TMR_W, 32, width of gauge and timeout counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
scl_pad_i  in  CH  raw SCL pad inputs, bit c = channel c
sda_pad_i  in  CH  raw SDA pad inputs
prescale  in  PRE_W  filter sample interval minus 1 (0 = sample every cycle)
gauge_en  in  1  enables SCL period measurement, all channels
timeout_lim  in  TMR_W  SCL-low timeout limit in clk cycles; 0 disables timeout
scl_i  out  CH  filtered, delayed SCL
sda_i  out  CH  filtered, delayed SDA
sta_det  out  CH  1-cycle pulse on START or repeated START
rsta_det  out  CH  1-cycle pulse on repeated START only
sto_det  out  CH  1-cycle pulse on STOP
scl_rise  out  CH  1-cycle pulse on filtered SCL rising edge
scl_fall  out  CH  1-cycle pulse on filtered SCL falling edge
busy  out  CH  bus busy
tmo  out  CH  1-cycle pulse when SCL-low timeout fires
thigh  out  CH*TMR_W  last SCL high period, channel c at [c*TMR_W +: TMR_W]
tlow  out  CH*TMR_W  last SCL low period, same packing

Behaviour:
- Reset is synchronous active-high and applies on the next clk edge with rst=1.
  - Reset values: sync flops, filter taps, s*/d* registers all 1; busy=0; all pulses 0; gauge and timeout counters 0; thigh/tlow all ones.
- Synchroniser: 2 flops per line.
- Prescaler: one counter shared by all channels.
  - When the counter is 0: tick=1 and the counter reloads prescale; otherwise it decrements.
  - A prescale change takes effect at the next reload.
- Filter: on tick, the synchronised bit shifts into a DEPTH-bit shift register.
  - Each cycle, s = (popcount(taps) > DEPTH/2), registered; d = s registered.
  - Pad-to-d latency with prescale=0: 2 sync + (DEPTH+1)/2 ticks + 2 cycles.
- Detection, all combinational from s/d:
  - sta_det = sSCL & dSCL & dSDA & ~sSDA
  - sto_det = sSCL & dSCL & ~dSDA & sSDA
  - rsta_det = sta_det & busy
  - scl_rise = ~dSCL & sSCL
  - scl_fall = dSCL & ~sSCL
  - scl_i = dSCL, sda_i = dSDA
- busy:
  - Set by sta_det.
  - Cleared by sto_det or tmo.
  - If sta_det and tmo occur in the same cycle, sta_det wins.
- Timeout counter:
  - Cleared when busy=0 or sSCL=1.
  - Increments while busy & ~sSCL, saturating.
  - tmo pulses for one cycle when the count equals timeout_lim (nonzero) and busy=1; the counter then holds, so there is no re-fire until SCL rises.
- Gauge, only when gauge_en=1:
  - The counter clears on scl_rise or scl_fall; otherwise it increments while busy and saturates at all ones.
  - On scl_rise, tlow <= count. On scl_fall, thigh <= count (pre-clear value).
  - With gauge_en=0, the counter and captures hold.
- Channels are fully independent apart from the shared prescaler tick and config inputs.
- Reset mid-transfer drops busy and any pulse in flight; the next detection requires a fresh START.

Decomposition:
- Shared package i2c_pkg:
  - default PRE_W/TMR_W constants;
  - majority(function, DEPTH-generic);
  - per-channel status struct {scl, sda, sta, rsta, sto, rise, fall, busy, tmo}.
- Sub-module i2c_chan_filter: sync, filter, detect, busy, timeout and gauge for one channel. Instantiated CH times via generate; the prescaler lives in the top level.

Test Plan:
1. CH=2, DEPTH=3, prescale=0. Ch0 drives SDA low while SCL high -> sta_det[0] one cycle, busy[0]=1 the next cycle, rsta_det[0]=0, and channel 1 stays quiet.
2. Ch0 busy, then SDA 1->0 with SCL high -> sta_det[0] and rsta_det[0] pulse together. SDA 0->1 with SCL high -> sto_det[0] pulses, then busy[0]=0.
3. prescale=9, DEPTH=5, 2-sample-wide (20-cycle) SCL low glitch -> no scl_fall/scl_rise. A 3-sample-wide low (30 cycles) -> scl_fall, then scl_rise.
4. gauge_en=1, busy, SCL 100 cycles low / 60 high (prescale=0) -> tlow=99, thigh=59 within ±1, stable across repeated periods. gauge_en=0 -> values freeze.
5. timeout_lim=50, busy, SCL held low -> tmo pulses once after 50 low cycles, busy drops. timeout_lim=0 -> no tmo.
6. Assert rst mid-transfer -> next cycle busy=0, thigh/tlow=FFFFFFFF, all pulses 0. An SDA rise after reset does not assert sto_det.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the multi-channel I2C input conditioner.
package i2c_pkg;

  localparam int unsigned PRE_W_DEF = 14;
  localparam int unsigned TMR_W_DEF = 32;
  localparam int unsigned MAX_DEPTH = 15;

  // Per-channel conditioned line levels and bus events
  typedef struct packed {
    logic scl;
    logic sda;
    logic sta;
    logic rsta;
    logic sto;
    logic rise;
    logic fall;
    logic busy;
    logic tmo;
  } chan_status_t;

  // Majority vote over the lowest 'depth' taps
  function automatic logic majority(input logic [MAX_DEPTH-1:0] taps,
                                    input int unsigned depth);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (i < depth && taps[i]) ones++;
    end
    return (ones > (depth / 2));
  endfunction

endpackage

// File: rtl/i2c_chan_filter.sv
// One I2C channel: synchroniser, majority filter, event detection,
// busy tracking, SCL-low timeout and SCL period gauge.
module i2c_chan_filter
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned TMR_W = TMR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               scl_pad,
  input  logic               sda_pad,
  input  logic               gauge_en,
  input  logic [TMR_W-1:0]   timeout_lim,
  output chan_status_t       status,
  output logic [TMR_W-1:0]   thigh,
  output logic [TMR_W-1:0]   tlow
);

  logic [1:0]       scl_sync, sda_sync;
  logic [DEPTH-1:0] scl_taps, sda_taps;
  logic             s_scl, s_sda, d_scl, d_sda;
  logic             busy_q;
  logic [TMR_W-1:0] tmo_cnt, gauge_cnt;
  logic             sta_c, sto_c, rise_c, fall_c, tmo_c, tmo_hold_c;

  // Synchronise pads, shift samples on tick, vote and delay one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_taps <= '1;
      sda_taps <= '1;
      s_scl    <= 1'b1;
      s_sda    <= 1'b1;
      d_scl    <= 1'b1;
      d_sda    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_pad};
      sda_sync <= {sda_sync[0], sda_pad};
      if (tick) begin
        scl_taps <= {scl_taps[DEPTH-2:0], scl_sync[1]};
        sda_taps <= {sda_taps[DEPTH-2:0], sda_sync[1]};
      end
      s_scl <= majority(MAX_DEPTH'(scl_taps), DEPTH);
      s_sda <= majority(MAX_DEPTH'(sda_taps), DEPTH);
      d_scl <= s_scl;
      d_sda <= s_sda;
    end
  end

  // Bus events decoded from current and previous filtered levels
  always_comb begin
    sta_c      = s_scl & d_scl & d_sda & ~s_sda;
    sto_c      = s_scl & d_scl & ~d_sda & s_sda;
    rise_c     = ~d_scl & s_scl;
    fall_c     = d_scl & ~s_scl;
    tmo_hold_c = (timeout_lim != '0) && (tmo_cnt == timeout_lim);
    tmo_c      = busy_q && tmo_hold_c;
  end

  // Busy: START sets, STOP or timeout clears, START has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else if (sta_c) begin
      busy_q <= 1'b1;
    end else if (sto_c || tmo_c) begin
      busy_q <= 1'b0;
    end
  end

  // SCL-low timeout counter, holds at the limit so it fires once
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (!busy_q || s_scl) begin
      tmo_cnt <= '0;
    end else if (!tmo_hold_c && (tmo_cnt != '1)) begin
      tmo_cnt <= tmo_cnt + TMR_W'(1);
    end
  end

  // SCL high/low period gauge, frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      gauge_cnt <= '0;
      thigh     <= '1;
      tlow      <= '1;
    end else if (gauge_en) begin
      if (rise_c) tlow  <= gauge_cnt;
      if (fall_c) thigh <= gauge_cnt;
      if (rise_c || fall_c) begin
        gauge_cnt <= '0;
      end else if (busy_q && (gauge_cnt != '1)) begin
        gauge_cnt <= gauge_cnt + TMR_W'(1);
      end
    end
  end

  // Pack channel status
  always_comb begin
    status      = '0;
    status.scl  = d_scl;
    status.sda  = d_sda;
    status.sta  = sta_c;
    status.rsta = sta_c & busy_q;
    status.sto  = sto_c;
    status.rise = rise_c;
    status.fall = fall_c;
    status.busy = busy_q;
    status.tmo  = tmo_c;
  end

endmodule

// File: rtl/i2c_bus_filter_mc.sv
// Multi-channel I2C input conditioner and bus monitor with a shared
// filter-sampling prescaler.
module i2c_bus_filter_mc
  import i2c_pkg::*;
#(
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned PRE_W = PRE_W_DEF,
  parameter int unsigned TMR_W = TMR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       scl_pad_i,
  input  logic [CH-1:0]       sda_pad_i,
  input  logic [PRE_W-1:0]    prescale,
  input  logic                gauge_en,
  input  logic [TMR_W-1:0]    timeout_lim,
  output logic [CH-1:0]       scl_i,
  output logic [CH-1:0]       sda_i,
  output logic [CH-1:0]       sta_det,
  output logic [CH-1:0]       rsta_det,
  output logic [CH-1:0]       sto_det,
  output logic [CH-1:0]       scl_rise,
  output logic [CH-1:0]       scl_fall,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       tmo,
  output logic [CH*TMR_W-1:0] thigh,
  output logic [CH*TMR_W-1:0] tlow
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  chan_status_t     st [CH];

  assign tick = (pre_cnt == '0);

  // Shared prescaler; a new prescale value is picked up on reload
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= prescale;
    end else begin
      pre_cnt <= pre_cnt - PRE_W'(1);
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    i2c_chan_filter #(
      .DEPTH (DEPTH),
      .TMR_W (TMR_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .scl_pad     (scl_pad_i[c]),
      .sda_pad     (sda_pad_i[c]),
      .gauge_en    (gauge_en),
      .timeout_lim (timeout_lim),
      .status      (st[c]),
      .thigh       (thigh[c*TMR_W +: TMR_W]),
      .tlow        (tlow[c*TMR_W +: TMR_W])
    );

    assign scl_i[c]    = st[c].scl;
    assign sda_i[c]    = st[c].sda;
    assign sta_det[c]  = st[c].sta;
    assign rsta_det[c] = st[c].rsta;
    assign sto_det[c]  = st[c].sto;
    assign scl_rise[c] = st[c].rise;
    assign scl_fall[c] = st[c].fall;
    assign busy[c]     = st[c].busy;
    assign tmo[c]      = st[c].tmo;
  end

endmodule
